// File: rtl/mem_responder_pkg.sv
// Shared types for the multi-channel memory responder.
//   ch_state_e : per-channel request FSM states
//   op_e       : captured operation kind
//   idx_width  : index width helper that never returns zero
package mem_responder_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACK  = 3'd3,
        ST_HOLD = 3'd4
    } ch_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_responder_rr_arbiter.sv
// Round-robin arbiter: grants the lowest-index requester at or after the
// pointer (wrapping); the pointer moves to grant+1 after every grant.
//   clk, rst_n  : clock, async active-low reset
//   req_i       : request vector
//   gnt_c       : one-hot grant (combinational)
//   gnt_idx_c   : binary index of the granted requester
//   gnt_any_c   : a grant is issued this cycle
module rr_arbiter
    import mem_responder_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned PTR_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_c,
    output logic [PTR_W-1:0] gnt_idx_c,
    output logic             gnt_any_c
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    int unsigned      cand;

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Scan from the pointer, first requester wins
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        ptr_d     = ptr_q;
        cand      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr_q) + k) % N;
            if (!gnt_any_c && (((req_i >> cand) & N'(1)) != '0)) begin
                gnt_any_c = 1'b1;
                gnt_c     = N'(1) << cand;
                gnt_idx_c = PTR_W'(cand);
                ptr_d     = PTR_W'((cand + 1) % N);
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-channel memory responder: each channel captures a read or write
// request, competes for the single shared array port through a round-robin
// arbiter, waits LATENCY cycles, then pulses its ready for one cycle.
//   clk, reset            : clock, async active-low reset
//   mem_read_valid/address: per-channel read request
//   mem_read_ready/data   : per-channel read-done pulse and held read data
//   mem_write_valid/address/data : per-channel write request
//   mem_write_ready       : per-channel write-done pulse
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned NUM_CHANNELS  = 2,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned LATENCY       = 2,
    parameter int unsigned WRITE_ENABLE  = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CHANNELS-1:0]               mem_read_valid,
    input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]               mem_read_ready,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]    mem_read_data,
    input  logic [NUM_CHANNELS-1:0]               mem_write_valid,
    input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] mem_write_address,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    mem_write_data,
    output logic [NUM_CHANNELS-1:0]               mem_write_ready
);

    localparam int unsigned IDX_W = idx_width(DEPTH);
    localparam int unsigned CH_W  = idx_width(NUM_CHANNELS);

    logic [NUM_CHANNELS-1:0]               req;
    logic [NUM_CHANNELS-1:0]               gnt;
    logic [CH_W-1:0]                       gnt_idx;
    logic                                  gnt_any;
    logic [NUM_CHANNELS-1:0]               op_vec;
    logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] addr_vec;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]    wdata_vec;

    logic [ADDRESS_WIDTH-1:0] acc_addr;
    logic [IDX_W-1:0]         acc_idx;
    logic [DATA_WIDTH-1:0]    acc_wdata;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     acc_wr;

    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

    rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
        .clk       (clk),
        .rst_n     (reset),
        .req_i     (req),
        .gnt_c     (gnt),
        .gnt_idx_c (gnt_idx),
        .gnt_any_c (gnt_any)
    );

    // Single array port, steered by the granted channel; upper address bits alias
    assign acc_addr  = ADDRESS_WIDTH'(addr_vec >> (ADDRESS_WIDTH * gnt_idx));
    assign acc_wdata = DATA_WIDTH'(wdata_vec >> (DATA_WIDTH * gnt_idx));
    assign acc_idx   = IDX_W'(acc_addr);
    assign acc_wr    = gnt_any && (op_vec[gnt_idx] == OP_WRITE) && (WRITE_ENABLE != 0);
    assign mem_rdata = mem_q[acc_idx];

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        ch_state_e                state_q, state_d;
        op_e                      op_q, op_d;
        logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
        logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
        logic [CNT_W-1:0]         cnt_q, cnt_d;
        logic                     rd_rdy_q, rd_rdy_d;
        logic                     wr_rdy_q, wr_rdy_d;
        logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

        logic                     rv, wv;
        logic [ADDRESS_WIDTH-1:0] raddr, waddr;
        logic [DATA_WIDTH-1:0]    wd;

        assign rv    = mem_read_valid[c];
        assign wv    = mem_write_valid[c];
        assign raddr = mem_read_address[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign waddr = mem_write_address[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign wd    = mem_write_data[c*DATA_WIDTH +: DATA_WIDTH];

        // Channel registers
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q  <= ST_IDLE;
                op_q     <= OP_READ;
                addr_q   <= '0;
                wdata_q  <= '0;
                cnt_q    <= '0;
                rd_rdy_q <= 1'b0;
                wr_rdy_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                state_q  <= state_d;
                op_q     <= op_d;
                addr_q   <= addr_d;
                wdata_q  <= wdata_d;
                cnt_q    <= cnt_d;
                rd_rdy_q <= rd_rdy_d;
                wr_rdy_q <= wr_rdy_d;
                rdata_q  <= rdata_d;
            end
        end

        // Channel FSM; ready defaults low so it is a single-cycle pulse
        always_comb begin
            state_d  = state_q;
            op_d     = op_q;
            addr_d   = addr_q;
            wdata_d  = wdata_q;
            cnt_d    = cnt_q;
            rd_rdy_d = 1'b0;
            wr_rdy_d = 1'b0;
            rdata_d  = rdata_q;
            case (state_q)
                ST_IDLE: begin
                    if (rv) begin
                        op_d    = OP_READ;
                        addr_d  = raddr;
                        state_d = ST_REQ;
                    end else if (wv) begin
                        op_d    = OP_WRITE;
                        addr_d  = waddr;
                        wdata_d = wd;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (gnt[c]) begin
                        cnt_d   = CNT_W'(LATENCY);
                        state_d = ST_WAIT;
                        if (op_q == OP_READ) begin
                            rdata_d = mem_rdata;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ACK;
                        if (op_q == OP_READ) begin
                            rd_rdy_d = 1'b1;
                        end else begin
                            wr_rdy_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_ACK: begin
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    // Wait for the served request to be withdrawn
                    if ((op_q == OP_READ && !rv) || (op_q == OP_WRITE && !wv)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        assign req[c]                                        = (state_q == ST_REQ);
        assign op_vec[c]                                     = op_q;
        assign addr_vec[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]    = addr_q;
        assign wdata_vec[c*DATA_WIDTH +: DATA_WIDTH]         = wdata_q;
        assign mem_read_ready[c]                             = rd_rdy_q;
        assign mem_write_ready[c]                            = wr_rdy_q;
        assign mem_read_data[c*DATA_WIDTH +: DATA_WIDTH]     = rdata_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: DUT A uses defaults (LATENCY=2, writes on),
// DUT B uses LATENCY=0 with writes disabled.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  a_rv, a_wv, a_rr, a_wr;
    logic [31:0] a_ra, a_wa;
    logic [63:0] a_wd, a_rd;
    logic [1:0]  b_rv, b_wv, b_rr, b_wr;
    logic [31:0] b_ra, b_wa;
    logic [63:0] b_wd, b_rd;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model for DUT A: word store indexed by address mod DEPTH,
    // plus the outstanding request per channel and its expected data.
    logic [31:0] mdl_mem [int];
    bit          rd_pend [2];
    bit          wr_pend [2];
    bit          rd_known[2];
    logic [31:0] rd_exp  [2];

    mem_responder u_a (
        .clk(clk), .reset(reset),
        .mem_read_valid(a_rv), .mem_read_address(a_ra),
        .mem_read_ready(a_rr), .mem_read_data(a_rd),
        .mem_write_valid(a_wv), .mem_write_address(a_wa),
        .mem_write_data(a_wd), .mem_write_ready(a_wr)
    );

    mem_responder #(.LATENCY(0), .WRITE_ENABLE(0)) u_b (
        .clk(clk), .reset(reset),
        .mem_read_valid(b_rv), .mem_read_address(b_ra),
        .mem_read_ready(b_rr), .mem_read_data(b_rd),
        .mem_write_valid(b_wv), .mem_write_address(b_wa),
        .mem_write_data(b_wd), .mem_write_ready(b_wr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    endfunction

    // Compare process: every ready pulse on DUT A must match an outstanding request
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (a_rr[i]) begin
                chk(rd_pend[i], "rd_pulse_expected", 64'(i), 64'(1));
                if (rd_pend[i] && rd_known[i])
                    chk(a_rd[i*32 +: 32] == rd_exp[i], "rd_data_model",
                        64'(a_rd[i*32 +: 32]), 64'(rd_exp[i]));
                rd_pend[i] = 1'b0;
            end
            if (a_wr[i]) begin
                chk(wr_pend[i], "wr_pulse_expected", 64'(i), 64'(1));
                wr_pend[i] = 1'b0;
            end
        end
    end

    task automatic model_issue(input bit c, input bit rd, input logic [15:0] a, input logic [31:0] d);
        int k;
        k = int'(a) % 1024;
        if (rd) begin
            rd_pend[c]  = 1'b1;
            rd_known[c] = mdl_mem.exists(k);
            rd_exp[c]   = rd_known[c] ? mdl_mem[k] : 32'h0;
        end else begin
            wr_pend[c] = 1'b1;
            mdl_mem[k] = d;
        end
    endtask

    task automatic drive(input bit sel, input bit c, input bit rd, input bit v,
                         input logic [15:0] a, input logic [31:0] d);
        if (!sel) begin
            if (rd) begin a_rv[c] = v; a_ra[c*16 +: 16] = a; end
            else begin a_wv[c] = v; a_wa[c*16 +: 16] = a; a_wd[c*32 +: 32] = d; end
        end else begin
            if (rd) begin b_rv[c] = v; b_ra[c*16 +: 16] = a; end
            else begin b_wv[c] = v; b_wa[c*16 +: 16] = a; b_wd[c*32 +: 32] = d; end
        end
    endtask

    function automatic bit rdy(input bit sel, input bit c, input bit rd);
        if (sel) return rd ? b_rr[c] : b_wr[c];
        return rd ? a_rr[c] : a_wr[c];
    endfunction

    // One request; lat = negedges from drive to the ready pulse
    task automatic single_op(input bit sel, input bit c, input bit rd, input logic [15:0] a,
                             input logic [31:0] d, input int hold,
                             output int lat, output logic [31:0] rdv);
        int t0;
        int pulses;
        bit seen;
        seen = 0; pulses = 0; lat = -1; rdv = '0;
        @(negedge clk);
        if (!sel) model_issue(c, rd, a, d);
        drive(sel, c, rd, 1'b1, a, d);
        t0 = cyc;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (rdy(sel, c, rd)) begin
                seen = 1;
                lat  = cyc - t0;
                rdv  = sel ? b_rd[c*32 +: 32] : a_rd[c*32 +: 32];
            end
        end
        if (!seen) chk(1'b0, "ready_timeout", 64'(0), 64'(1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rdy(sel, c, rd)) pulses++;
        end
        if (hold > 0) chk(pulses == 0, "hold_no_repulse", 64'(pulses), 64'(0));
        drive(sel, c, rd, 1'b0, a, d);
        repeat (3) @(negedge clk);
    endtask

    task automatic dual_read(input logic [15:0] a0, input logic [15:0] a1,
                             output int l0, output int l1,
                             output logic [31:0] d0, output logic [31:0] d1);
        int t0;
        l0 = -1; l1 = -1; d0 = '0; d1 = '0;
        @(negedge clk);
        model_issue(1'b0, 1'b1, a0, '0);
        model_issue(1'b1, 1'b1, a1, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, a0, '0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, a1, '0);
        t0 = cyc;
        for (int i = 0; i < 60 && (l0 < 0 || l1 < 0); i++) begin
            @(negedge clk);
            if (l0 < 0 && a_rr[0]) begin l0 = cyc - t0; d0 = a_rd[31:0];  a_rv[0] = 1'b0; end
            if (l1 < 0 && a_rr[1]) begin l1 = cyc - t0; d1 = a_rd[63:32]; a_rv[1] = 1'b0; end
        end
        if (l0 < 0 || l1 < 0) chk(1'b0, "dual_timeout", 64'(0), 64'(1));
        a_rv = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l1, lat, rl, wl, t0, pulses;
        logic [31:0] d0, d1, rdv;

        a_rv = '0; a_wv = '0; a_ra = '0; a_wa = '0; a_wd = '0;
        b_rv = '0; b_wv = '0; b_ra = '0; b_wa = '0; b_wd = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk(a_rr == 2'b00, "rst_a_rd_ready", 64'(a_rr), 64'(0));
        chk(a_wr == 2'b00, "rst_a_wr_ready", 64'(a_wr), 64'(0));
        chk(a_rd == 64'h0, "rst_a_rd_data", a_rd, 64'h0);
        chk(b_rr == 2'b00 && b_wr == 2'b00 && b_rd == 64'h0, "rst_b_outputs", b_rd, 64'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Write then read 0x0010: ready lands on E0+4
        single_op(0, 0, 0, 16'h0010, 32'hDEADBEEF, 0, lat, rdv);
        chk(lat == 5, "wr_lat_lat2", 64'(lat), 64'(5));
        @(negedge clk);
        model_issue(1'b0, 1'b1, 16'h0010, '0);
        drive(0, 0, 1, 1, 16'h0010, '0);
        t0 = cyc; lat = -1;
        for (int i = 0; i < 60 && lat < 0; i++) begin
            @(negedge clk);
            if (a_rr[0]) begin lat = cyc - t0; rdv = a_rd[31:0]; end
        end
        chk(lat == 5, "rd_lat_lat2", 64'(lat), 64'(5));
        chk(rdv == 32'hDEADBEEF, "rd_data_deadbeef", 64'(rdv), 64'hDEADBEEF);
        @(negedge clk);
        chk(a_rr[0] == 1'b0, "rd_pulse_one_cycle", 64'(a_rr[0]), 64'(0));
        a_rv[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Pointer is now 1; ch1 write moves it to 0
        single_op(0, 1, 0, 16'h0020, 32'hCAFEF00D, 0, lat, rdv);
        dual_read(16'h0010, 16'h0020, l0, l1, d0, d1);
        chk(l0 == 5, "rr_ptr0_ch0_first", 64'(l0), 64'(5));
        chk(l1 == 6, "rr_ptr0_ch1_second", 64'(l1), 64'(6));
        chk(d1 == 32'hCAFEF00D, "rr_ch1_data", 64'(d1), 64'hCAFEF00D);
        // Pointer ended at 0, so ch0 wins again
        dual_read(16'h0020, 16'h0010, l0, l1, d0, d1);
        chk(l0 == 5 && l1 == 6, "rr_ptr_back_to_0", 64'(l1), 64'(6));
        // A lone ch0 access leaves the pointer at 1, so ch1 wins
        single_op(0, 0, 1, 16'h0020, '0, 0, lat, rdv);
        dual_read(16'h0010, 16'h0020, l0, l1, d0, d1);
        chk(l1 == 5, "rr_ptr1_ch1_first", 64'(l1), 64'(5));
        chk(l0 == 6, "rr_ptr1_ch0_second", 64'(l0), 64'(6));

        // Address aliasing: 0x0405 and 0x0005 share index 5
        single_op(0, 1, 0, 16'h0405, 32'h5, 0, lat, rdv);
        single_op(0, 0, 1, 16'h0005, '0, 0, lat, rdv);
        chk(rdv == 32'h5, "alias_0405_0005", 64'(rdv), 64'h5);

        // Valid held 6 cycles past ready: single pulse, then normal service
        single_op(0, 1, 1, 16'h0010, '0, 6, lat, rdv);
        chk(lat == 5, "hold_rd_lat", 64'(lat), 64'(5));
        single_op(0, 1, 1, 16'h0005, '0, 0, lat, rdv);
        chk(lat == 5 && rdv == 32'h5, "after_hold_rd", 64'(rdv), 64'h5);

        // Read and write together on ch0: read first, write afterwards
        @(negedge clk);
        model_issue(1'b0, 1'b1, 16'h0020, '0);
        model_issue(1'b0, 1'b0, 16'h0020, 32'h11112222);
        drive(0, 0, 1, 1, 16'h0020, '0);
        drive(0, 0, 0, 1, 16'h0020, 32'h11112222);
        t0 = cyc; rl = -1; wl = -1;
        for (int i = 0; i < 60 && (rl < 0 || wl < 0); i++) begin
            @(negedge clk);
            if (rl < 0 && a_rr[0]) begin rl = cyc - t0; rdv = a_rd[31:0]; a_rv[0] = 1'b0; end
            if (wl < 0 && a_wr[0]) begin wl = cyc - t0; a_wv[0] = 1'b0; end
        end
        a_rv[0] = 1'b0; a_wv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk(rl == 5, "rw_read_first_lat", 64'(rl), 64'(5));
        chk(wl > rl, "rw_write_after_read", 64'(wl), 64'(rl));
        chk(rdv == 32'hCAFEF00D, "rw_read_old_data", 64'(rdv), 64'hCAFEF00D);
        single_op(0, 1, 1, 16'h0020, '0, 0, lat, rdv);
        chk(rdv == 32'h11112222, "rw_write_committed", 64'(rdv), 64'h11112222);

        // Reset during WAIT: no pulse, outputs cleared at once
        @(negedge clk);
        model_issue(1'b0, 1'b1, 16'h0010, '0);
        drive(0, 0, 1, 1, 16'h0010, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        a_rv = '0;
        rd_pend[0] = 1'b0;
        #1;
        chk(a_rr == 2'b00 && a_wr == 2'b00, "rst_mid_ready", 64'({a_rr, a_wr}), 64'(0));
        chk(a_rd == 64'h0, "rst_mid_rd_data", a_rd, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_rr != 2'b00 || a_wr != 2'b00) pulses++;
        end
        chk(pulses == 0, "rst_mid_no_pulse", 64'(pulses), 64'(0));
        single_op(0, 0, 1, 16'h0010, '0, 0, lat, rdv);
        chk(lat == 5 && rdv == 32'hDEADBEEF, "post_rst_read", 64'(rdv), 64'hDEADBEEF);

        // DUT B: LATENCY=0, writes acknowledged but never stored
        single_op(1, 0, 0, 16'h0020, 32'h1234, 0, lat, rdv);
        chk(lat == 3, "weoff_wr_lat0", 64'(lat), 64'(3));
        single_op(1, 0, 1, 16'h0020, '0, 0, lat, rdv);
        chk(lat == 3, "weoff_rd_lat0", 64'(lat), 64'(3));
        chk(rdv != 32'h1234, "weoff_not_written", 64'(rdv), 64'h1234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
